// File: rtl/turn_signal_pkg.sv
// Shared types and width helpers for the turn/hazard/brake lamp sequencer.
// No latency or backpressure: declarations only.
// Counter widths are derived from LAMPS and HOLD by the helpers below.
package turn_signal_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEFT    = 3'd1,
        RIGHT   = 3'd2,
        HAZ_ON  = 3'd3,
        HAZ_OFF = 3'd4
    } state_t;

    // Step runs 0..lamps inclusive; the extra value is the dark gap.
    function automatic int step_w(input int lamps);
        return $clog2(lamps + 1);
    endfunction

    // A one-tick hold still needs a 1-bit counter so the port stays legal.
    function automatic int hold_w(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

    // Both hazard phases belong to one request class.
    function automatic state_t state_class(input state_t s);
        return (s == HAZ_OFF) ? HAZ_ON : s;
    endfunction

endpackage

// File: rtl/tsig_pattern.sv
// Combinational lamp pattern for one bank: one-hot walk or thermometer fill.
// Latency: zero, purely combinational.
// Backpressure: none; the output follows step and fill directly.
module tsig_pattern
    import turn_signal_pkg::*;
#(
    parameter int LAMPS = 3,
    parameter int SW    = step_w(LAMPS)
) (
    input  logic [SW-1:0]    step,
    input  logic             fill,
    output logic [LAMPS-1:0] pat
);

    always_comb begin
        pat = '0;
        // step == LAMPS is the dark gap, so every lamp stays off there.
        if (step < SW'(LAMPS)) begin
            for (int i = 0; i < LAMPS; i++) begin
                pat[i] = fill ? (SW'(i) <= step) : (SW'(i) == step);
            end
        end
    end

endmodule

// File: rtl/turn_signal_seq.sv
// Turn/hazard/brake lamp sequencer driving two banks of LAMPS lamps each.
// Latency: one clk_out edge from request sample to registered lamp output.
// Backpressure: none; level inputs are decoded on every edge.
module turn_signal_seq
    import turn_signal_pkg::*;
#(
    parameter int LAMPS = 3,
    parameter int HOLD  = 1
) (
    input  logic             clk_out,
    input  logic             rst,
    input  logic             left,
    input  logic             right,
    input  logic             hazard,
    input  logic             brake,
    input  logic             fill_mode,
    output logic [LAMPS-1:0] y_l,
    output logic [LAMPS-1:0] y_r
);

    localparam int SW = step_w(LAMPS);
    localparam int HW = hold_w(HOLD);

    state_t           state_q, state_d, req;
    logic [SW-1:0]    step_q, step_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic             mode_q, mode_d;
    logic [LAMPS-1:0] y_l_d, y_r_d, pat, brk;

    tsig_pattern #(.LAMPS(LAMPS), .SW(SW)) u_pattern (
        .step (step_d),
        .fill (mode_d),
        .pat  (pat)
    );

    always_ff @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            hold_q  <= '0;
            mode_q  <= 1'b0;
            y_l     <= '0;
            y_r     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            y_l     <= y_l_d;
            y_r     <= y_r_d;
        end
    end

    always_comb begin
        req = IDLE;
        if (hazard || (left && right)) req = HAZ_ON;
        else if (left)                 req = LEFT;
        else if (right)                req = RIGHT;

        state_d = state_q;
        step_d  = step_q;
        hold_d  = hold_q;
        mode_d  = mode_q;

        if (state_class(state_q) != req) begin
            state_d = req;
            step_d  = '0;
            hold_d  = '0;
            mode_d  = fill_mode;
        end else if (state_q != IDLE) begin
            if (hold_q == HW'(HOLD - 1)) begin
                hold_d = '0;
                case (state_q)
                    HAZ_ON:  state_d = HAZ_OFF;
                    HAZ_OFF: state_d = HAZ_ON;
                    default: step_d  = (step_q == SW'(LAMPS)) ? '0 : step_q + 1'b1;
                endcase
            end else begin
                hold_d = hold_q + 1'b1;
            end
        end

        // Outputs come from the next-state values so they track this edge's decision.
        brk   = brake ? {LAMPS{1'b1}} : '0;
        y_l_d = '0;
        y_r_d = '0;
        case (state_d)
            IDLE: begin
                y_l_d = brk;
                y_r_d = brk;
            end
            LEFT: begin
                y_l_d = pat;
                y_r_d = brk;
            end
            RIGHT: begin
                y_l_d = brk;
                y_r_d = pat;
            end
            HAZ_ON: begin
                y_l_d = {LAMPS{1'b1}};
                y_r_d = {LAMPS{1'b1}};
            end
            default: begin
                y_l_d = '0;
                y_r_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Bench for turn_signal_seq: two instances (HOLD=2 and HOLD=1, LAMPS=3) checked
// every cycle against a tick-count model, plus directed literal expectations.
module tb_turn_signal_seq;
    localparam int LAMPS  = 3;
    localparam int HOLD_A = 2;
    localparam int HOLD_B = 1;

    logic clk_out = 1'b0;
    logic rst = 1'b0;
    logic left = 1'b0, right = 1'b0, hazard = 1'b0, brake = 1'b0, fill_mode = 1'b0;
    logic [LAMPS-1:0] y_l_a, y_r_a, y_l_b, y_r_b;

    int checks = 0;
    int failures = 0;

    always #5 clk_out = ~clk_out;

    turn_signal_seq #(.LAMPS(LAMPS), .HOLD(HOLD_A)) dut_a (
        .clk_out(clk_out), .rst(rst), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .fill_mode(fill_mode), .y_l(y_l_a), .y_r(y_r_a)
    );

    turn_signal_seq #(.LAMPS(LAMPS), .HOLD(HOLD_B)) dut_b (
        .clk_out(clk_out), .rst(rst), .left(left), .right(right), .hazard(hazard),
        .brake(brake), .fill_mode(fill_mode), .y_l(y_l_b), .y_r(y_r_b)
    );

    // Model: class 0 idle, 1 left, 2 right, 3 hazard; t counts ticks since the class began.
    int   m_cls [2];
    int   m_t   [2];
    bit   m_fill[2];
    logic [2:0] m_l[2], m_r[2];

    function automatic int req_class(input logic l, input logic r, input logic h);
        if (h || (l && r)) return 3;
        if (l) return 1;
        if (r) return 2;
        return 0;
    endfunction

    function automatic logic [2:0] sweep(input int s, input bit f);
        int v;
        if (s == LAMPS) v = 0;
        else if (f)     v = (1 << (s + 1)) - 1;
        else            v = 1 << s;
        return v[2:0];
    endfunction

    always @(posedge clk_out or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                m_cls[k] = 0; m_t[k] = 0; m_fill[k] = 1'b0; m_l[k] = 3'b000; m_r[k] = 3'b000;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int c, h;
                logic [2:0] bk;
                h  = (k == 0) ? HOLD_A : HOLD_B;
                c  = req_class(left, right, hazard);
                bk = brake ? 3'b111 : 3'b000;
                if (c != m_cls[k]) begin
                    m_cls[k] = c; m_t[k] = 0; m_fill[k] = fill_mode;
                end else begin
                    m_t[k] = m_t[k] + 1;
                end
                case (c)
                    0: begin m_l[k] = bk; m_r[k] = bk; end
                    1: begin m_l[k] = sweep((m_t[k] / h) % (LAMPS + 1), m_fill[k]); m_r[k] = bk; end
                    2: begin m_l[k] = bk; m_r[k] = sweep((m_t[k] / h) % (LAMPS + 1), m_fill[k]); end
                    default: begin
                        m_l[k] = (((m_t[k] / h) % 2) == 0) ? 3'b111 : 3'b000;
                        m_r[k] = m_l[k];
                    end
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_out) begin
        chk("model_a_yl", y_l_a, m_l[0]);
        chk("model_a_yr", y_r_a, m_r[0]);
        chk("model_b_yl", y_l_b, m_l[1]);
        chk("model_b_yr", y_r_b, m_r[1]);
    end

    task automatic tick();
        @(posedge clk_out);
        #1;
    endtask

    logic [2:0] exp_left  [10];
    logic [2:0] exp_fill  [5];
    logic [2:0] exp_haz   [8];

    initial begin
        exp_left = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b000, 3'b000, 3'b001, 3'b001};
        exp_fill = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
        exp_haz  = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000};

        // Reset held with requests active.
        left = 1'b1; brake = 1'b1;
        repeat (3) tick();
        chk("reset_yl", y_l_a, 3'b000);
        chk("reset_yr", y_r_a, 3'b000);
        rst = 1'b1; left = 1'b0; brake = 1'b0;
        tick();
        chk("idle_yl", y_l_a, 3'b000);

        // Left one-hot, HOLD=2.
        left = 1'b1; fill_mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("left_onehot_yl", y_l_a, exp_left[i]);
            chk("left_onehot_yr", y_r_a, 3'b000);
        end
        left = 1'b0;
        tick();
        chk("left_drop_yl", y_l_a, 3'b000);

        // Right fill on the HOLD=1 instance.
        right = 1'b1; fill_mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("right_fill_h1_yr", y_r_b, exp_fill[i]);
        end
        right = 1'b0; fill_mode = 1'b0;
        tick();

        // Hazard, then brake added mid-blink.
        hazard = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 6) brake = 1'b1;
            tick();
            chk("hazard_yl", y_l_a, exp_haz[i]);
            chk("hazard_yr", y_r_a, exp_haz[i]);
        end
        hazard = 1'b0; brake = 1'b0; left = 1'b1; right = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lr_hazard_yl", y_l_a, exp_haz[i]);
        end
        right = 1'b0;
        tick();
        chk("lr_drop_right_yl", y_l_a, 3'b001);
        chk("lr_drop_right_yr", y_r_a, 3'b000);
        left = 1'b0;
        tick();

        // Brake during a left turn.
        left = 1'b1; brake = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("brake_turn_yl", y_l_a, exp_left[i]);
            chk("brake_turn_yr", y_r_a, 3'b111);
        end
        left = 1'b0;
        tick();
        chk("brake_idle_yl", y_l_a, 3'b111);
        chk("brake_idle_yr", y_r_a, 3'b111);
        brake = 1'b0;
        tick();

        // Direction switch with no idle gap.
        left = 1'b1;
        repeat (3) tick();
        chk("pre_switch_yl", y_l_a, 3'b010);
        left = 1'b0; right = 1'b1;
        tick();
        chk("switch_yl", y_l_a, 3'b000);
        chk("switch_yr", y_r_a, 3'b001);

        // fill_mode change mid-sequence stays ignored.
        fill_mode = 1'b1;
        tick();
        chk("fill_ignored_0", y_r_a, 3'b001);
        tick();
        chk("fill_ignored_1", y_r_a, 3'b010);

        // Asynchronous reset mid-sweep, checked before any further edge.
        rst = 1'b0;
        #1;
        chk("async_reset_yr", y_r_a, 3'b000);
        chk("async_reset_yl", y_l_a, 3'b000);
        tick();
        rst = 1'b1; right = 1'b0; fill_mode = 1'b0;
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
